spu_issue_scoreboard: RTL and testbench

- Dual-issue hazard controller for the REG->EX pipeline register stage.
- Tracks in-flight destination registers in a per-register latency scoreboard.
- Each cycle it decides which of the two REG-stage instructions may advance into EX.
- Drives per-slot kill (bubble) signals into the REG->EX register and a stall back to fetch/decode. It supports branch flush and counts stall cycles.

---
 rtl/spu_issue_scoreboard.sv | 104 ++++++++++
 tb/tb_spu_issue_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_issue_scoreboard.sv
// rtl/spu_issue_scoreboard.sv - dual-issue REG->EX hazard controller with per-register latency scoreboard
module spu_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int REG_AW   = 7,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_REG1,
  input  logic              valid_REG2,
  input  logic              regWriteEnable_REG1,
  input  logic              regWriteEnable_REG2,
  input  logic [REG_AW-1:0] readRegisterRA_REG1,
  input  logic [REG_AW-1:0] readRegisterRB_REG1,
  input  logic [REG_AW-1:0] readRegisterRC_REG1,
  input  logic [REG_AW-1:0] readRegisterRT_REG1,
  input  logic [REG_AW-1:0] readRegisterRA_REG2,
  input  logic [REG_AW-1:0] readRegisterRB_REG2,
  input  logic [REG_AW-1:0] readRegisterRC_REG2,
  input  logic [REG_AW-1:0] readRegisterRT_REG2,
  input  logic              useRA_REG1,
  input  logic              useRB_REG1,
  input  logic              useRC_REG1,
  input  logic              useRA_REG2,
  input  logic              useRB_REG2,
  input  logic              useRC_REG2,
  input  logic              evenPipe_REG1,
  input  logic              evenPipe_REG2,
  input  logic [LAT_W-1:0]  latency_REG1,
  input  logic [LAT_W-1:0]  latency_REG2,
  input  logic              flush,
  output logic              issue_EX1,
  output logic              issue_EX2,
  output logic              kill_EX1,
  output logic              kill_EX2,
  output logic              stall_REG,
  output logic [CNT_W-1:0]  stall_count
);

  logic [LAT_W-1:0] cnt [NUM_REGS];

  logic [LAT_W-1:0] load1, load2;
  logic             raw1, raw2, waw1, waw2;
  logic             src_dep, same_rt, same_pipe, pair_conflict;
  logic             wr1, wr2;

  // Latency 0 behaves as 1, so the reload value is max(L,1)-1.
  assign load1 = (latency_REG1 == '0) ? '0 : latency_REG1 - LAT_W'(1);
  assign load2 = (latency_REG2 == '0) ? '0 : latency_REG2 - LAT_W'(1);

  assign raw1 = (useRA_REG1 && cnt[readRegisterRA_REG1] != '0) ||
                (useRB_REG1 && cnt[readRegisterRB_REG1] != '0) ||
                (useRC_REG1 && cnt[readRegisterRC_REG1] != '0);
  assign raw2 = (useRA_REG2 && cnt[readRegisterRA_REG2] != '0) ||
                (useRB_REG2 && cnt[readRegisterRB_REG2] != '0) ||
                (useRC_REG2 && cnt[readRegisterRC_REG2] != '0);

  // A new writer must not finish before an older in-flight write to the same register.
  assign waw1 = regWriteEnable_REG1 && (cnt[readRegisterRT_REG1] > load1);
  assign waw2 = regWriteEnable_REG2 && (cnt[readRegisterRT_REG2] > load2);

  assign src_dep = regWriteEnable_REG1 &&
                   ((useRA_REG2 && readRegisterRA_REG2 == readRegisterRT_REG1) ||
                    (useRB_REG2 && readRegisterRB_REG2 == readRegisterRT_REG1) ||
                    (useRC_REG2 && readRegisterRC_REG2 == readRegisterRT_REG1));
  assign same_rt   = regWriteEnable_REG1 && regWriteEnable_REG2 &&
                     (readRegisterRT_REG1 == readRegisterRT_REG2);
  assign same_pipe = (evenPipe_REG1 == evenPipe_REG2);
  assign pair_conflict = src_dep || same_rt || same_pipe;

  assign issue_EX1 = valid_REG1 && !flush && !raw1 && !waw1;
  assign issue_EX2 = valid_REG2 && !flush && issue_EX1 && !raw2 && !waw2 && !pair_conflict;
  assign kill_EX1  = !issue_EX1;
  assign kill_EX2  = !issue_EX2;
  assign stall_REG = !flush && ((valid_REG1 && !issue_EX1) || (valid_REG2 && !issue_EX2));

  assign wr1 = issue_EX1 && regWriteEnable_REG1;
  assign wr2 = issue_EX2 && regWriteEnable_REG2;

  // Same-RT dual issue is blocked by pair_conflict, so the two loads never collide.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        cnt[r] <= '0;
      end else if (wr1 && readRegisterRT_REG1 == REG_AW'(r)) begin
        cnt[r] <= load1;
      end else if (wr2 && readRegisterRT_REG2 == REG_AW'(r)) begin
        cnt[r] <= load2;
      end else if (cnt[r] != '0) begin
        cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_REG && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// tb/tb_spu_issue_scoreboard.sv - bench for spu_issue_scoreboard
module tb_spu_issue_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic v1, v2, we1, we2, ua1, ub1, uc1, ua2, ub2, uc2, ev1, ev2, fl;
  logic [6:0] ra1, rb1, rc1, rt1, ra2, rb2, rc2, rt2;
  logic [2:0] l1, l2;
  logic i1, i2, k1, k2, st;
  logic [31:0] scnt;

  int n_checks = 0;
  int n_fail = 0;

  // Reference: cycle at which each register's pending result becomes usable.
  int ready [128];
  int now = 0;
  int m_stalls = 0;

  spu_issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .valid_REG1(v1), .valid_REG2(v2),
    .regWriteEnable_REG1(we1), .regWriteEnable_REG2(we2),
    .readRegisterRA_REG1(ra1), .readRegisterRB_REG1(rb1),
    .readRegisterRC_REG1(rc1), .readRegisterRT_REG1(rt1),
    .readRegisterRA_REG2(ra2), .readRegisterRB_REG2(rb2),
    .readRegisterRC_REG2(rc2), .readRegisterRT_REG2(rt2),
    .useRA_REG1(ua1), .useRB_REG1(ub1), .useRC_REG1(uc1),
    .useRA_REG2(ua2), .useRB_REG2(ub2), .useRC_REG2(uc2),
    .evenPipe_REG1(ev1), .evenPipe_REG2(ev2),
    .latency_REG1(l1), .latency_REG2(l2),
    .flush(fl),
    .issue_EX1(i1), .issue_EX2(i2), .kill_EX1(k1), .kill_EX2(k2),
    .stall_REG(st), .stall_count(scnt)
  );

  typedef struct packed {
    logic v1, v2, we1, we2, ua1, ub1, uc1, ua2, ub2, uc2, ev1, ev2, fl;
    logic [6:0] ra1, rb1, rc1, rt1, ra2, rb2, rc2, rt2;
    logic [2:0] l1, l2;
    logic e_i1, e_i2, e_st;
  } vec_t;

  vec_t vecs [11];

  function automatic int eff(logic [2:0] l);
    return (l == 3'd0) ? 1 : int'(l);
  endfunction

  task automatic model_eval(output logic e1, output logic e2, output logic est);
    logic raw1, raw2, waw1, waw2, pc;
    raw1 = (ua1 && ready[ra1] > now) || (ub1 && ready[rb1] > now) || (uc1 && ready[rc1] > now);
    raw2 = (ua2 && ready[ra2] > now) || (ub2 && ready[rb2] > now) || (uc2 && ready[rc2] > now);
    waw1 = we1 && (ready[rt1] > now + eff(l1) - 1);
    waw2 = we2 && (ready[rt2] > now + eff(l2) - 1);
    pc = (we1 && ((ua2 && ra2 == rt1) || (ub2 && rb2 == rt1) || (uc2 && rc2 == rt1))) ||
         (we1 && we2 && rt1 == rt2) || (ev1 == ev2);
    e1 = v1 && !fl && !raw1 && !waw1;
    e2 = v2 && !fl && e1 && !raw2 && !waw2 && !pc;
    est = !fl && ((v1 && !e1) || (v2 && !e2));
  endtask

  task automatic tick();
    logic e1, e2, est;
    model_eval(e1, e2, est);
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 128; r++) ready[r] = 0;
      m_stalls = 0;
    end else begin
      if (e1 && we1) ready[rt1] = now + eff(l1);
      if (e2 && we2) ready[rt2] = now + eff(l2);
      if (est) m_stalls++;
    end
    now++;
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, logic e1, logic e2, logic est);
    check({tag, " issue_EX1"}, 32'(i1), 32'(e1));
    check({tag, " issue_EX2"}, 32'(i2), 32'(e2));
    check({tag, " kill_EX1"}, 32'(k1), 32'(!e1));
    check({tag, " kill_EX2"}, 32'(k2), 32'(!e2));
    check({tag, " stall_REG"}, 32'(st), 32'(est));
  endtask

  task automatic clear_inputs();
    {v1, v2, we1, we2, ua1, ub1, uc1, ua2, ub2, uc2, ev1, ev2, fl} = '0;
    {ra1, rb1, rc1, rt1, ra2, rb2, rc2, rt2} = '0;
    l1 = 3'd1;
    l2 = 3'd1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic apply(vec_t t);
    v1 = t.v1; v2 = t.v2; we1 = t.we1; we2 = t.we2;
    ua1 = t.ua1; ub1 = t.ub1; uc1 = t.uc1; ua2 = t.ua2; ub2 = t.ub2; uc2 = t.uc2;
    ev1 = t.ev1; ev2 = t.ev2; fl = t.fl;
    ra1 = t.ra1; rb1 = t.rb1; rc1 = t.rc1; rt1 = t.rt1;
    ra2 = t.ra2; rb2 = t.rb2; rc2 = t.rc2; rt2 = t.rt2;
    l1 = t.l1; l2 = t.l2;
  endtask

  initial begin
    logic e1, e2, est;

    vecs[0]  = '{v1:1, we1:1, ra1:5, ua1:1, rt1:10, l1:1, e_i1:1, default:'0};
    vecs[1]  = '{v1:1, we1:1, rt1:20, ev1:1, v2:1, ub2:1, rb2:20, rt2:21, e_i1:1, e_st:1, default:'0};
    vecs[2]  = '{v1:1, we1:1, rt1:3, ev1:1, v2:1, we2:1, rt2:4, ev2:1, e_i1:1, e_st:1, default:'0};
    vecs[3]  = '{v1:1, we1:1, rt1:3, ev1:1, v2:1, we2:1, rt2:4, e_i1:1, e_i2:1, default:'0};
    vecs[4]  = '{v1:1, we1:1, rt1:9, v2:1, we2:1, rt2:9, ev2:1, e_i1:1, e_st:1, default:'0};
    vecs[5]  = '{v1:1, v2:1, ev2:1, fl:1, default:'0};
    vecs[6]  = '{v2:1, ev2:1, e_st:1, default:'0};
    vecs[7]  = '{default:'0};
    vecs[8]  = '{v1:1, rt1:11, v2:1, uc2:1, rc2:11, ev2:1, e_i1:1, e_i2:1, default:'0};
    vecs[9]  = '{v1:1, we1:1, rt1:11, v2:1, ua2:1, ra2:11, ev2:1, e_i1:1, e_st:1, default:'0};
    vecs[10] = '{v1:1, we1:1, rt1:11, v2:1, rc2:11, ev2:1, e_i1:1, e_i2:1, default:'0};

    reset = 1'b1;
    clear_inputs();
    for (int r = 0; r < 128; r++) ready[r] = 0;
    reset_dut();
    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset stall_count", scnt, 32'd0);
    tick();

    for (int n = 0; n < 11; n++) begin
      reset_dut();
      apply(vecs[n]);
      #2;
      check_outs($sformatf("vec%0d", n), vecs[n].e_i1, vecs[n].e_i2, vecs[n].e_st);
      tick();
    end

    // RAW on a latency-4 producer: three stall cycles, then issue.
    reset_dut();
    v1 = 1; we1 = 1; rt1 = 10; l1 = 3'd4;
    #2; check("raw producer issue", 32'(i1), 32'd1);
    tick();
    clear_inputs(); v1 = 1; ua1 = 1; ra1 = 10;
    for (int k = 1; k <= 3; k++) begin
      #2; check_outs($sformatf("raw wait%0d", k), 1'b0, 1'b0, 1'b1);
      tick();
    end
    #2; check_outs("raw release", 1'b1, 1'b0, 1'b0);
    check("raw stall_count", scnt, 32'd3);
    tick();

    // Latency 0 acts as 1: dependent issues back-to-back.
    reset_dut();
    v1 = 1; we1 = 1; rt1 = 12; l1 = 3'd0;
    #2; check("lat0 producer", 32'(i1), 32'd1);
    tick();
    clear_inputs(); v1 = 1; ua1 = 1; ra1 = 12;
    #2; check_outs("lat0 dependent", 1'b1, 1'b0, 1'b0);
    tick();

    // Flush kills a hazarded slot without disturbing the countdown.
    reset_dut();
    v1 = 1; we1 = 1; rt1 = 10; l1 = 3'd3;
    tick();
    clear_inputs(); v1 = 1; ua1 = 1; ra1 = 10; fl = 1;
    #2; check_outs("flush", 1'b0, 1'b0, 1'b0);
    tick();
    fl = 0;
    #2; check_outs("post flush wait", 1'b0, 1'b0, 1'b1);
    tick();
    #2; check_outs("post flush release", 1'b1, 1'b0, 1'b0);
    check("flush stall_count", scnt, 32'd1);
    tick();

    // WAW: lat-6 writer to r7, then lat-2 writer to r7.
    reset_dut();
    v1 = 1; we1 = 1; rt1 = 7; l1 = 3'd6;
    tick();
    l1 = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      #2; check_outs($sformatf("waw wait%0d", k), 1'b0, 1'b0, 1'b1);
      tick();
    end
    #2; check_outs("waw release", 1'b1, 1'b0, 1'b0);
    tick();

    // Dual issue loads both counters in the same cycle.
    reset_dut();
    v1 = 1; we1 = 1; rt1 = 3; l1 = 3'd2; ev1 = 1;
    v2 = 1; we2 = 1; rt2 = 4; l2 = 3'd3; ev2 = 0;
    #2; check_outs("dual load", 1'b1, 1'b1, 1'b0);
    tick();
    clear_inputs(); v1 = 1; ua1 = 1; ra1 = 3;
    #2; check_outs("dual r3 wait", 1'b0, 1'b0, 1'b1);
    tick();
    v2 = 1; ub2 = 1; rb2 = 4; ev1 = 1;
    #2; check_outs("dual r3 ready r4 busy", 1'b1, 1'b0, 1'b1);
    tick();
    clear_inputs(); v1 = 1; ua1 = 1; ra1 = 4;
    #2; check_outs("dual r4 ready", 1'b1, 1'b0, 1'b0);
    tick();

    // Reset mid-operation discards pending results.
    reset_dut();
    v1 = 1; we1 = 1; rt1 = 10; l1 = 3'd7;
    tick();
    clear_inputs(); v1 = 1; ua1 = 1; ra1 = 10;
    #2; check_outs("pre reset wait", 1'b0, 1'b0, 1'b1);
    reset = 1;
    tick();
    reset = 0;
    #2; check_outs("after mid reset", 1'b1, 1'b0, 1'b0);
    check("mid reset stall_count", scnt, 32'd0);
    tick();

    // Random traffic on a small register window against the reference.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
      ua1 = 1'($urandom_range(0, 1)); ub1 = 1'($urandom_range(0, 1)); uc1 = 1'($urandom_range(0, 1));
      ua2 = 1'($urandom_range(0, 1)); ub2 = 1'($urandom_range(0, 1)); uc2 = 1'($urandom_range(0, 1));
      ev1 = 1'($urandom_range(0, 1)); ev2 = 1'($urandom_range(0, 1));
      ra1 = 7'($urandom_range(0, 7)); rb1 = 7'($urandom_range(0, 7));
      rc1 = 7'($urandom_range(0, 7)); rt1 = 7'($urandom_range(0, 7));
      ra2 = 7'($urandom_range(0, 7)); rb2 = 7'($urandom_range(0, 7));
      rc2 = 7'($urandom_range(0, 7)); rt2 = 7'($urandom_range(0, 7));
      l1 = 3'($urandom_range(0, 7)); l2 = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 15) == 0);
      #2;
      model_eval(e1, e2, est);
      check_outs($sformatf("rand%0d", c), e1, e2, est);
      check($sformatf("rand%0d stall_count", c), scnt, 32'(m_stalls));
      tick();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
